// File: rtl/branch_unit.sv
// Program-counter and branch controller for the simplex8 core: condition
// evaluation, jump/call/return sequencing and a small hardware return stack.
module branch_unit #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned STACK_DEPTH = 4,
   localparam int unsigned DW         = $clog2(STACK_DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              STALL,
   input  logic              JUMP,
   input  logic              CALL,
   input  logic              RET,
   input  logic [2:0]        COND,
   input  logic              NEG,
   input  logic [ADDR_W-1:0] TARGET,
   input  logic [7:0]        FLAGS,
   output logic [ADDR_W-1:0] PC,
   output logic              TAKEN,
   output logic [DW-1:0]     DEPTH,
   output logic              STACK_ERR
);

   localparam int unsigned IW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
   localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

   logic [ADDR_W-1:0] stack [STACK_DEPTH];

   logic              cond;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_next;
   logic [DW-1:0]     depth_next;
   logic              taken_next;
   logic              err_next;
   logic              push;
   logic [IW-1:0]     top_idx;
   logic [IW-1:0]     push_idx;

   assign cond     = FLAGS[COND] ^ NEG;
   assign pc_inc   = PC + ADDR_W'(1);
   // Entry DEPTH-1 is the top of stack; a push writes entry DEPTH.
   assign top_idx  = IW'(DEPTH - DW'(1));
   assign push_idx = IW'(DEPTH);

   always_comb begin
      pc_next    = pc_inc;
      depth_next = DEPTH;
      taken_next = 1'b0;
      err_next   = STACK_ERR;
      push       = 1'b0;
      if (STALL) begin
         pc_next = PC;
      end else if (RET && cond) begin
         if (DEPTH != '0) begin
            pc_next    = stack[top_idx];
            depth_next = DEPTH - DW'(1);
            taken_next = 1'b1;
         end else begin
            err_next = 1'b1;
         end
      end else if (CALL && cond) begin
         if (DEPTH != FULL) begin
            push       = 1'b1;
            pc_next    = TARGET;
            depth_next = DEPTH + DW'(1);
            taken_next = 1'b1;
         end else begin
            err_next = 1'b1;
         end
      end else if (JUMP && cond) begin
         pc_next    = TARGET;
         taken_next = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         PC        <= '0;
         TAKEN     <= 1'b0;
         DEPTH     <= '0;
         STACK_ERR <= 1'b0;
      end else begin
         PC        <= pc_next;
         TAKEN     <= taken_next;
         DEPTH     <= depth_next;
         STACK_ERR <= err_next;
      end
   end

   // Stack contents are don't-care after reset, so no reset is applied here.
   always_ff @(posedge CLK) begin
      if (push) begin
         stack[push_idx] <= pc_inc;
      end
   end

endmodule

// File: tb/tb_branch_unit.sv
// Scoreboard bench for branch_unit: directed vectors push hand-computed
// expectations; a negedge monitor pops and compares them.
module tb_branch_unit;

   logic       CLK = 1'b0;
   logic       RESET_N = 1'b0;
   logic       STALL = 1'b0;
   logic       JUMP = 1'b0;
   logic       CALL = 1'b0;
   logic       RET = 1'b0;
   logic [2:0] COND = '0;
   logic       NEG = 1'b0;
   logic [7:0] TARGET = '0;
   logic [7:0] FLAGS = 8'h01;
   logic [7:0] PC;
   logic       TAKEN;
   logic [2:0] DEPTH;
   logic       STACK_ERR;

   typedef struct {
      logic [7:0] pc;
      logic       taken;
      logic [2:0] depth;
      logic       err;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   branch_unit #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
      .CLK(CLK), .RESET_N(RESET_N), .STALL(STALL), .JUMP(JUMP), .CALL(CALL),
      .RET(RET), .COND(COND), .NEG(NEG), .TARGET(TARGET), .FLAGS(FLAGS),
      .PC(PC), .TAKEN(TAKEN), .DEPTH(DEPTH), .STACK_ERR(STACK_ERR)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   // Monitor: outputs are compared on the falling edge, away from the active edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", int'(PC), int'(e.pc));
            chk("taken", int'(TAKEN), int'(e.taken));
            chk("depth", int'(DEPTH), int'(e.depth));
            chk("stack_err", int'(STACK_ERR), int'(e.err));
         end
      end
   end

   // One cycle: drive requests, queue the expected post-edge state; with mid=1
   // reset is pulled low shortly after the edge to exercise the asynchronous clear.
   task automatic step(input logic j, input logic c, input logic r,
                       input logic [2:0] cnd, input logic n, input logic [7:0] tgt,
                       input logic [7:0] flg, input logic stl, input logic mid,
                       input logic [7:0] epc, input logic etk,
                       input logic [2:0] edp, input logic eer);
      exp_t e;
      @(negedge CLK);
      #1;
      RESET_N = 1'b1;
      JUMP = j; CALL = c; RET = r; COND = cnd; NEG = n;
      TARGET = tgt; FLAGS = flg; STALL = stl;
      e.pc = epc; e.taken = etk; e.depth = edp; e.err = eer;
      q.push_back(e);
      @(posedge CLK);
      if (mid) begin
         #2;
         RESET_N = 1'b0;
      end
   endtask

   initial begin
      exp_t e0;
      e0.pc = 8'h00; e0.taken = 1'b0; e0.depth = 3'd0; e0.err = 1'b0;
      q.push_back(e0);
      // j c r cond neg tgt flags stall mid | pc taken depth err
      for (int i = 1; i <= 5; i++)
         step(0,0,0,3'd0,0,8'h00,8'h01,0,0, 8'(i),0,3'd0,0);
      step(0,0,0,3'd0,0,8'h00,8'h01,0,1, 8'h00,0,3'd0,0);
      step(0,0,0,3'd0,0,8'h00,8'h01,0,0, 8'h01,0,3'd0,0);
      // conditional jump on EQ, then the same with NEG
      step(1,0,0,3'd1,0,8'h40,8'h03,0,0, 8'h40,1,3'd0,0);
      step(1,0,0,3'd1,1,8'h40,8'h03,0,0, 8'h41,0,3'd0,0);
      step(1,0,0,3'd0,0,8'h10,8'h03,0,0, 8'h10,1,3'd0,0);
      step(0,1,0,3'd0,0,8'h80,8'h03,0,0, 8'h80,1,3'd1,0);
      step(0,0,1,3'd0,0,8'h00,8'h03,0,0, 8'h11,1,3'd0,0);
      // CALL on LT with LT clear is not taken
      step(0,1,0,3'd2,0,8'h99,8'h03,0,0, 8'h12,0,3'd0,0);
      // fill the stack, overflow, drain, underflow
      step(0,1,0,3'd0,0,8'h20,8'h01,0,0, 8'h20,1,3'd1,0);
      step(0,1,0,3'd0,0,8'h30,8'h01,0,0, 8'h30,1,3'd2,0);
      step(0,1,0,3'd0,0,8'h50,8'h01,0,0, 8'h50,1,3'd3,0);
      step(0,1,0,3'd0,0,8'h60,8'h01,0,0, 8'h60,1,3'd4,0);
      step(0,1,0,3'd0,0,8'h70,8'h01,0,0, 8'h61,0,3'd4,1);
      step(0,0,1,3'd0,0,8'h00,8'h01,0,0, 8'h51,1,3'd3,1);
      step(0,0,1,3'd0,0,8'h00,8'h01,0,0, 8'h31,1,3'd2,1);
      step(0,0,1,3'd0,0,8'h00,8'h01,0,0, 8'h21,1,3'd1,1);
      step(0,0,1,3'd0,0,8'h00,8'h01,0,0, 8'h13,1,3'd0,1);
      step(0,0,1,3'd0,0,8'h00,8'h01,0,0, 8'h14,0,3'd0,1);
      // priority RET > CALL > JUMP, then stall
      step(0,1,0,3'd0,0,8'h90,8'h01,0,0, 8'h90,1,3'd1,1);
      step(1,1,1,3'd0,0,8'hA0,8'h01,0,0, 8'h15,1,3'd0,1);
      step(1,0,0,3'd0,0,8'hA0,8'h01,1,0, 8'h15,0,3'd0,1);
      // other flags: nonzero with NEG, LT set
      step(1,0,0,3'd6,1,8'hB0,8'h44,0,0, 8'h16,0,3'd0,1);
      step(1,0,0,3'd2,0,8'hFE,8'h44,0,0, 8'hFE,1,3'd0,1);
      // PC wrap and CALL at 0xFF pushing 0x00
      step(0,0,0,3'd0,0,8'h00,8'h01,0,0, 8'hFF,0,3'd0,1);
      step(0,0,0,3'd0,0,8'h00,8'h01,0,0, 8'h00,0,3'd0,1);
      step(1,0,0,3'd0,0,8'hFF,8'h01,0,0, 8'hFF,1,3'd0,1);
      step(0,1,0,3'd0,0,8'h20,8'h01,0,0, 8'h20,1,3'd1,1);
      step(0,0,0,3'd0,0,8'h00,8'h01,0,0, 8'h21,0,3'd1,1);
      step(0,0,1,3'd0,0,8'h00,8'h01,0,0, 8'h00,1,3'd0,1);
      // "never" condition
      step(1,0,0,3'd0,1,8'h77,8'h01,0,0, 8'h01,0,3'd0,1);
      // async reset after a taken CALL clears everything, including the sticky error
      step(0,1,0,3'd0,0,8'h33,8'h01,0,1, 8'h00,0,3'd0,0);
      step(0,0,0,3'd0,0,8'h00,8'h01,0,0, 8'h01,0,3'd0,0);
      step(0,0,0,3'd0,0,8'h00,8'h01,0,0, 8'h02,0,3'd0,0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge CLK);
      #1;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "timeout");
   end

endmodule
